btle_hci_cmd_seq: RTL

BTLE_HCI_CMD_SEQ -- requirements
Module: btle_hci_cmd_seq

---
 rtl/btle_hci_cmd_seq_pkg.sv | 42 ++++
 rtl/btle_hci_cmd_seq_timeout.sv | 28 ++
 rtl/btle_hci_cmd_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/btle_hci_cmd_seq_pkg.sv
// Shared opcode, status and state definitions for the BTLE HCI command sequencer.
package btle_hci_cmd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_LEN,
    ST_GET_PAYLOAD,
    ST_EXEC,
    ST_WAIT_PHY,
    ST_RESP
  } state_t;

  localparam logic [7:0] OP_GAUSS = 8'h01;
  localparam logic [7:0] OP_AA    = 8'h02;
  localparam logic [7:0] OP_CHAN  = 8'h03;
  localparam logic [7:0] OP_CRC   = 8'h04;
  localparam logic [7:0] OP_PDU   = 8'h05;
  localparam logic [7:0] OP_TX    = 8'h06;

  localparam logic [7:0] STS_OK      = 8'h00;
  localparam logic [7:0] STS_UNKNOWN = 8'h01;
  localparam logic [7:0] STS_BAD_LEN = 8'h02;
  localparam logic [7:0] STS_RX_ERR  = 8'h03;
  localparam logic [7:0] STS_TIMEOUT = 8'h04;

  function automatic logic op_known(input logic [7:0] op);
    return (op >= OP_GAUSS) && (op <= OP_TX);
  endfunction

  function automatic logic len_valid(input logic [7:0] op, input logic [7:0] len);
    case (op)
      OP_GAUSS: return len == 8'd9;
      OP_AA:    return len == 8'd4;
      OP_CHAN:  return len == 8'd1;
      OP_CRC:   return len == 8'd3;
      OP_PDU:   return (len >= 8'd1) && (len <= 8'd64);
      OP_TX:    return len == 8'd0;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/btle_hci_cmd_seq_timeout.sv
// Inter-byte timeout down-counter: reloads on load, counts down while enabled.
module btle_hci_timeout #(
  parameter int unsigned LOAD_VALUE = 16000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [31:0] LOAD_WORD = 32'(LOAD_VALUE);

  logic [31:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_WORD;
    end else if (enable && (count != '0)) begin
      count <= count - 32'd1;
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/btle_hci_cmd_seq.sv
// UART-driven HCI command sequencer: parses opcode/length/payload frames and
// programs the BTLE PHY (gauss taps, access address, CRC init, channel, PDU, tx start).
module btle_hci_cmd_seq
  import btle_hci_cmd_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCE          = 16_000_000,
  parameter int unsigned TIMEOUT_US             = 1000,
  parameter int unsigned GAUSS_FILTER_BIT_WIDTH = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        rx_byte,
  input  logic                              rx_valid,
  input  logic                              rx_err,
  output logic [7:0]                        resp_byte,
  output logic                              resp_en,
  input  logic                              resp_busy,
  output logic [3:0]                        gauss_tap_index,
  output logic [GAUSS_FILTER_BIT_WIDTH-1:0] gauss_tap_value,
  output logic                              gauss_tap_we,
  output logic [31:0]                       access_address,
  output logic [23:0]                       crc_init,
  output logic [5:0]                        channel_number,
  output logic [5:0]                        pdu_mem_addr,
  output logic [7:0]                        pdu_mem_data,
  output logic                              pdu_mem_we,
  output logic                              tx_start,
  input  logic                              tx_done,
  output logic                              busy
);

  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_US * (CLK_FREQUENCE / 1_000_000);

  state_t      state, state_next;
  logic [7:0]  opcode;
  logic [7:0]  len;
  logic [7:0]  pos;
  logic [7:0]  status;
  logic [31:0] shadow;

  logic to_expired;
  logic in_frame;
  logic abort_err, abort_to;
  logic take_len, take_byte;

  assign in_frame = (state == ST_GET_LEN) || (state == ST_GET_PAYLOAD);

  btle_hci_timeout #(
    .LOAD_VALUE (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (rx_valid),
    .enable  (in_frame),
    .expired (to_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // rx_err outranks a coincident timeout, and both outrank a coincident byte.
  always_comb begin
    state_next = state;
    abort_err  = 1'b0;
    abort_to   = 1'b0;
    take_len   = 1'b0;
    take_byte  = 1'b0;
    tx_start   = 1'b0;
    resp_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid) state_next = ST_GET_LEN;
      end
      ST_GET_LEN: begin
        if (rx_err) begin
          abort_err  = 1'b1;
          state_next = ST_RESP;
        end else if (to_expired) begin
          abort_to   = 1'b1;
          state_next = ST_RESP;
        end else if (rx_valid) begin
          take_len   = 1'b1;
          state_next = (rx_byte == 8'd0) ? ST_EXEC : ST_GET_PAYLOAD;
        end
      end
      ST_GET_PAYLOAD: begin
        if (rx_err) begin
          abort_err  = 1'b1;
          state_next = ST_RESP;
        end else if (to_expired) begin
          abort_to   = 1'b1;
          state_next = ST_RESP;
        end else if (rx_valid) begin
          take_byte = 1'b1;
          if (pos == len - 8'd1) state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        tx_start   = (opcode == OP_TX) && (status == STS_OK);
        state_next = tx_start ? ST_WAIT_PHY : ST_RESP;
      end
      ST_WAIT_PHY: begin
        if (tx_done) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (!resp_busy) begin
          resp_en    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode          <= '0;
      len             <= '0;
      pos             <= '0;
      status          <= '0;
      shadow          <= '0;
      gauss_tap_we    <= 1'b0;
      gauss_tap_index <= '0;
      gauss_tap_value <= '0;
      pdu_mem_we      <= 1'b0;
      pdu_mem_addr    <= '0;
      pdu_mem_data    <= '0;
      access_address  <= '0;
      crc_init        <= '0;
      channel_number  <= '0;
    end else begin
      gauss_tap_we <= 1'b0;
      pdu_mem_we   <= 1'b0;

      if ((state == ST_IDLE) && rx_valid) opcode <= rx_byte;

      if (take_len) begin
        len <= rx_byte;
        pos <= '0;
        if (!op_known(opcode))               status <= STS_UNKNOWN;
        else if (!len_valid(opcode, rx_byte)) status <= STS_BAD_LEN;
        else                                  status <= STS_OK;
      end

      // Bad or unknown frames still advance pos so the payload is drained.
      if (take_byte) begin
        pos <= pos + 8'd1;
        if (status == STS_OK) begin
          case (opcode)
            OP_GAUSS: begin
              gauss_tap_we    <= 1'b1;
              gauss_tap_index <= pos[3:0];
              gauss_tap_value <= rx_byte[GAUSS_FILTER_BIT_WIDTH-1:0];
            end
            OP_PDU: begin
              pdu_mem_we   <= 1'b1;
              pdu_mem_addr <= pos[5:0];
              pdu_mem_data <= rx_byte;
            end
            OP_AA, OP_CHAN, OP_CRC: begin
              case (pos[1:0])
                2'd0: shadow[7:0]   <= rx_byte;
                2'd1: shadow[15:8]  <= rx_byte;
                2'd2: shadow[23:16] <= rx_byte;
                default: shadow[31:24] <= rx_byte;
              endcase
            end
            default: ;
          endcase
        end
      end

      if (abort_err)     status <= STS_RX_ERR;
      else if (abort_to) status <= STS_TIMEOUT;

      if ((state == ST_EXEC) && (status == STS_OK)) begin
        case (opcode)
          OP_AA:   access_address <= shadow;
          OP_CHAN: channel_number <= shadow[5:0];
          OP_CRC:  crc_init       <= shadow[23:0];
          default: ;
        endcase
      end
    end
  end

  assign resp_byte = status;
  assign busy      = (state != ST_IDLE);

endmodule
